// File: rtl/mac_unit.sv
// mac_unit: four 40-bit accumulators behind a two-stage multiply/accumulate pipeline.
// The RND op (110) exists only when MAC_UNIT_ROUND_EN is defined; otherwise it decodes as NOP.
module mac_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  acc_sel_i,
  input  logic [15:0] opa_i,
  input  logic [15:0] opb_i,
  input  logic        sat_en_i,
  output logic [39:0] value_o,
  output logic        do_sat_o,
  input  logic [39:0] sat_value_i,
  input  logic        did_sat_i,
  output logic        valid_o,
  input  logic [1:0]  acc_rd_sel_i,
  output logic [39:0] acc_rd_o,
  output logic [3:0]  ovf_o
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_CLR  = 3'b001,
    OP_MUL  = 3'b010,
    OP_MAC  = 3'b011,
    OP_MDM  = 3'b100,
    OP_LDA  = 3'b101,
    OP_RND  = 3'b110,
    OP_NOP7 = 3'b111
  } op_e;

  op_e         s1_op_reg;
  logic [1:0]  s1_sel_reg;
  logic        s1_sat_en_reg;
  logic [31:0] s1_data_reg;

  logic [31:0] product;
  logic [39:0] acc_file [4];
  logic [39:0] sel_acc;
  logic [39:0] data_ext;
  logic [39:0] value_next;
  logic        write_next;
  logic        clr_next;

  // Operands are widened to 32 bits first so the low 32 bits hold the full signed product.
  assign product = $signed({{16{opa_i[15]}}, opa_i}) * $signed({{16{opb_i[15]}}, opb_i});

  // LDA shares the product field: {opa, opb} sign-extended is exactly the LDA value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_op_reg     <= OP_NOP;
      s1_sel_reg    <= '0;
      s1_sat_en_reg <= 1'b0;
      s1_data_reg   <= '0;
    end else if (valid_i) begin
      s1_op_reg     <= op_e'(op_i);
      s1_sel_reg    <= acc_sel_i;
      s1_sat_en_reg <= sat_en_i;
      s1_data_reg   <= (op_i == OP_LDA) ? {opa_i, opb_i} : product;
    end else begin
      s1_op_reg     <= OP_NOP;
    end
  end

  assign sel_acc  = acc_file[s1_sel_reg];
  assign data_ext = {{8{s1_data_reg[31]}}, s1_data_reg};

  always_comb begin
    value_next = '0;
    write_next = 1'b0;
    clr_next   = 1'b0;
    case (s1_op_reg)
      OP_CLR: clr_next = 1'b1;
      OP_MUL, OP_LDA: begin
        write_next = 1'b1;
        value_next = data_ext;
      end
      OP_MAC: begin
        write_next = 1'b1;
        value_next = sel_acc + data_ext;
      end
      OP_MDM: begin
        write_next = 1'b1;
        value_next = sel_acc - data_ext;
      end
`ifdef MAC_UNIT_ROUND_EN
      // Adding 0x8000 then zeroing [15:0] only carries into bit 16 when bit 15 is set.
      OP_RND: begin
        write_next = 1'b1;
        value_next = {sel_acc[39:16] + {23'd0, sel_acc[15]}, 16'h0000};
      end
`endif
      default: ;
    endcase
  end

  assign valid_o  = write_next;
  assign do_sat_o = write_next & s1_sat_en_reg;
  assign value_o  = value_next;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_acc
      logic [39:0] acc_reg;
      logic        ovf_reg;
      logic        hit;

      assign hit = (s1_sel_reg == 2'(gi));

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (hit && clr_next) begin
          acc_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (hit && write_next) begin
          acc_reg <= sat_value_i;
          ovf_reg <= ovf_reg | did_sat_i;
        end
      end

      assign acc_file[gi] = acc_reg;
      assign ovf_o[gi]    = ovf_reg;
    end
  endgenerate

  assign acc_rd_o = acc_file[acc_rd_sel_i];

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: directed and randomized checks of mac_unit with a 32-bit signed saturation stage
// closing the writeback loop; random ops are checked against a sequential arithmetic model.
module tb_mac_unit;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [1:0]  acc_sel_i;
  logic [15:0] opa_i;
  logic [15:0] opb_i;
  logic        sat_en_i;
  logic [39:0] value_o;
  logic        do_sat_o;
  logic [39:0] sat_value_i;
  logic        did_sat_i;
  logic        valid_o;
  logic [1:0]  acc_rd_sel_i;
  logic [39:0] acc_rd_o;
  logic [3:0]  ovf_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, MUL = 3'd2, MAC = 3'd3,
                         MDM = 3'd4, LDA = 3'd5, RND = 3'd6;

  mac_unit dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .op_i(op_i),
    .acc_sel_i(acc_sel_i), .opa_i(opa_i), .opb_i(opb_i), .sat_en_i(sat_en_i),
    .value_o(value_o), .do_sat_o(do_sat_o), .sat_value_i(sat_value_i),
    .did_sat_i(did_sat_i), .valid_o(valid_o), .acc_rd_sel_i(acc_rd_sel_i),
    .acc_rd_o(acc_rd_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Saturation stage: clamp to the signed 32-bit range when requested.
  logic signed [39:0] sv;
  always_comb begin
    sv          = value_o;
    sat_value_i = value_o;
    did_sat_i   = 1'b0;
    if (do_sat_o && sv > 40'sh007FFFFFFF) begin
      sat_value_i = 40'h007FFFFFFF;
      did_sat_i   = 1'b1;
    end else if (do_sat_o && sv < 40'shFF80000000) begin
      sat_value_i = 40'hFF80000000;
      did_sat_i   = 1'b1;
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sel,
                       input logic [15:0] a, input logic [15:0] b, input logic sat);
    valid_i = v; op_i = op; acc_sel_i = sel; opa_i = a; opb_i = b; sat_en_i = sat;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    acc_rd_sel_i = 2'd0;
    drive(1'b1, LDA, 2'd0, 16'h1234, 16'h5678, 1'b0);  // must be ignored during reset
    tick();
    tick();
    reset_i = 1'b0;
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_checks++; if (do_sat_o !== 1'b0) begin n_fail++; $display("FAIL reset_do_sat: got %b want 0", do_sat_o); end
    n_checks++; if (value_o !== 40'h0) begin n_fail++; $display("FAIL reset_value: got %h want 0", value_o); end
    n_checks++; if (ovf_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf: got %b want 0000", ovf_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      acc_rd_sel_i = 2'(i);
      #1;
      n_checks++; if (acc_rd_o !== 40'h0) begin n_fail++; $display("FAIL reset_acc%0d: got %h want 0", i, acc_rd_o); end
    end
  endtask

  task automatic test_mul();
    drive(1'b1, MUL, 2'd0, 16'h0003, 16'hFFFE, 1'b0);
    acc_rd_sel_i = 2'd0;
    tick();
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mul_valid: got %b want 1", valid_o); end
    n_checks++; if (value_o !== 40'hFFFFFFFFFA) begin n_fail++; $display("FAIL mul_value: got %h want fffffffffa", value_o); end
    n_checks++; if (acc_rd_o !== 40'h0) begin n_fail++; $display("FAIL mul_latency: got %h want 0 before writeback", acc_rd_o); end
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
    n_checks++; if (acc_rd_o !== 40'hFFFFFFFFFA) begin n_fail++; $display("FAIL mul_acc0: got %h want fffffffffa", acc_rd_o); end
    n_checks++; if (valid_o !== 1'b0 || value_o !== 40'h0) begin n_fail++; $display("FAIL mul_idle: got valid %b value %h want 0/0", valid_o, value_o); end
  endtask

  task automatic test_mac_chain();
    drive(1'b1, CLR, 2'd1, 16'h0, 16'h0, 1'b0);
    acc_rd_sel_i = 2'd1;
    tick();
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", valid_o); end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, MAC, 2'd1, 16'h7FFF, 16'h7FFF, 1'b0);
      tick();
      n_checks++;
      if (value_o !== 40'(k * 64'h3FFF0001)) begin
        n_fail++; $display("FAIL mac_chain_value%0d: got %h want %h", k, value_o, 40'(k * 64'h3FFF0001));
      end
    end
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
    n_checks++; if (acc_rd_o !== 40'h00FFFC0004) begin n_fail++; $display("FAIL mac_chain_acc1: got %h want 00fffc0004", acc_rd_o); end
    n_checks++; if (ovf_o[1] !== 1'b0) begin n_fail++; $display("FAIL mac_chain_ovf1: got %b want 0", ovf_o[1]); end
  endtask

  task automatic test_saturation();
    logic [3:0] ovf_before;
    ovf_before = ovf_o;
    acc_rd_sel_i = 2'd2;
    drive(1'b1, LDA, 2'd2, 16'h7FFF, 16'hFFFF, 1'b0);
    tick();
    n_checks++; if (value_o !== 40'h007FFFFFFF) begin n_fail++; $display("FAIL lda_value: got %h want 007fffffff", value_o); end
    drive(1'b1, MAC, 2'd2, 16'h0001, 16'h0001, 1'b1);
    tick();
    n_checks++; if (value_o !== 40'h0080000000) begin n_fail++; $display("FAIL sat_value: got %h want 0080000000", value_o); end
    n_checks++; if (do_sat_o !== 1'b1) begin n_fail++; $display("FAIL sat_do_sat: got %b want 1", do_sat_o); end
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
    n_checks++; if (acc_rd_o !== 40'h007FFFFFFF) begin n_fail++; $display("FAIL sat_acc2: got %h want 007fffffff", acc_rd_o); end
    n_checks++; if (ovf_o !== (ovf_before | 4'b0100)) begin n_fail++; $display("FAIL sat_ovf: got %b want %b", ovf_o, ovf_before | 4'b0100); end
    drive(1'b1, CLR, 2'd2, 16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
    n_checks++; if (acc_rd_o !== 40'h0) begin n_fail++; $display("FAIL clr_acc2: got %h want 0", acc_rd_o); end
    n_checks++; if (ovf_o !== (ovf_before & 4'b1011)) begin n_fail++; $display("FAIL clr_ovf: got %b want %b", ovf_o, ovf_before & 4'b1011); end
  endtask

  task automatic test_reset_discard();
    acc_rd_sel_i = 2'd3;
    drive(1'b1, LDA, 2'd3, 16'h1234, 16'h5678, 1'b0);
    tick();
    drive(1'b1, MAC, 2'd3, 16'h0001, 16'h0001, 1'b0);
    tick();
    n_checks++; if (acc_rd_o !== 40'h0012345678) begin n_fail++; $display("FAIL discard_pre_acc3: got %h want 0012345678", acc_rd_o); end
    n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL discard_pre_valid: got %b want 1", valid_o); end
    reset_i = 1'b1;
    drive(1'b1, MAC, 2'd3, 16'h0001, 16'h0001, 1'b0);
    tick();
    reset_i = 1'b0;
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL discard_valid: got %b want 0", valid_o); end
    n_checks++; if (acc_rd_o !== 40'h0) begin n_fail++; $display("FAIL discard_acc3: got %h want 0", acc_rd_o); end
    n_checks++; if (ovf_o !== 4'b0000) begin n_fail++; $display("FAIL discard_ovf: got %b want 0000", ovf_o); end
  endtask

  task automatic test_round();
    acc_rd_sel_i = 2'd0;
    drive(1'b1, LDA, 2'd0, 16'h0001, 16'h8000, 1'b0);
    tick();
    drive(1'b1, RND, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
`ifdef MAC_UNIT_ROUND_EN
    n_checks++; if (valid_o !== 1'b1 || value_o !== 40'h0000020000) begin n_fail++; $display("FAIL rnd_s1: got valid %b value %h want 1/0000020000", valid_o, value_o); end
`else
    n_checks++; if (valid_o !== 1'b0 || value_o !== 40'h0) begin n_fail++; $display("FAIL rnd_s1: got valid %b value %h want 0/0", valid_o, value_o); end
`endif
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
`ifdef MAC_UNIT_ROUND_EN
    n_checks++; if (acc_rd_o !== 40'h0000020000) begin n_fail++; $display("FAIL rnd_acc0: got %h want 0000020000", acc_rd_o); end
`else
    n_checks++; if (acc_rd_o !== 40'h0000018000) begin n_fail++; $display("FAIL rnd_acc0: got %h want 0000018000", acc_rd_o); end
`endif
  endtask

  task automatic test_random();
    longint     m_acc [4];
    logic [3:0] m_ovf;
    longint     mask, prod, ev, s, res;
    logic       ew, did, v, sat;
    logic [2:0] op;
    logic [1:0] sel;
    logic [15:0] a, b;
    mask = (longint'(1) << 40) - 1;
    reset_i = 1'b1;
    drive(1'b0, NOP, 2'd0, 16'h0, 16'h0, 1'b0);
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
    m_ovf = 4'b0000;
    for (int it = 0; it < 400; it++) begin
      v   = ($urandom_range(0, 7) != 0);
      op  = 3'($urandom_range(0, 7));
      sel = 2'($urandom_range(0, 3));
      a   = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      sat = 1'($urandom_range(0, 1));
      drive(v, op, sel, a, b, sat);
      acc_rd_sel_i = 2'($urandom_range(0, 3));
      tick();
      prod = longint'($signed(a)) * longint'($signed(b));
      ew = 1'b0;
      ev = 0;
      if (v) begin
        case (op)
          MUL: begin ew = 1'b1; ev = prod & mask; end
          MAC: begin ew = 1'b1; ev = (m_acc[sel] + prod) & mask; end
          MDM: begin ew = 1'b1; ev = (m_acc[sel] - prod) & mask; end
          LDA: begin ew = 1'b1; ev = longint'($signed({a, b})) & mask; end
`ifdef MAC_UNIT_ROUND_EN
          RND: begin ew = 1'b1; ev = ((m_acc[sel] + 64'h8000) & mask) & ~longint'(64'hFFFF); end
`endif
          default: ;
        endcase
      end
      n_checks++; if (valid_o !== ew) begin n_fail++; $display("FAIL rand%0d_valid: op %0d got %b want %b", it, op, valid_o, ew); end
      n_checks++; if (value_o !== 40'(ev)) begin n_fail++; $display("FAIL rand%0d_value: op %0d got %h want %h", it, op, value_o, 40'(ev)); end
      n_checks++; if (do_sat_o !== (ew & sat)) begin n_fail++; $display("FAIL rand%0d_do_sat: got %b want %b", it, do_sat_o, ew & sat); end
      n_checks++; if (acc_rd_o !== 40'(m_acc[acc_rd_sel_i])) begin n_fail++; $display("FAIL rand%0d_acc_rd%0d: got %h want %h", it, acc_rd_sel_i, acc_rd_o, 40'(m_acc[acc_rd_sel_i])); end
      n_checks++; if (ovf_o !== m_ovf) begin n_fail++; $display("FAIL rand%0d_ovf: got %b want %b", it, ovf_o, m_ovf); end
      if (ew) begin
        s   = (ev & (longint'(1) << 39)) != 0 ? ev - (longint'(1) << 40) : ev;
        res = ev;
        did = 1'b0;
        if (sat && s > 64'sd2147483647) begin res = 64'h7FFFFFFF; did = 1'b1; end
        else if (sat && s < -64'sd2147483648) begin res = (-64'sd2147483648) & mask; did = 1'b1; end
        m_acc[sel] = res;
        m_ovf[sel] = m_ovf[sel] | did;
      end else if (v && op == CLR) begin
        m_acc[sel] = 0;
        m_ovf[sel] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mac_chain();
    test_saturation();
    test_reset_discard();
    test_round();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
